// File: rtl/rr_bus_mux.sv
// rr_bus_mux: registered N_SRC-to-1 bus multiplexer with direct and round-robin selection.
//
// Selects one of N_SRC source words onto a shared WIDTH-bit bus and registers the result,
// together with a one-hot grant and the granted index.
//
// Modes:
//   mode = 0 : direct select. The control unit drives sel; an out-of-range sel idles the bus.
//   mode = 1 : round-robin arbitration between asserted req bits, starting one past the last
//              winner. With lock = 1 the current owner keeps the bus while its req stays high.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, priority over everything
//   data_in    flattened source words, source i at [i*WIDTH +: WIDTH]
//   req        per-source request (arbitrated mode only)
//   mode       0 = direct, 1 = round-robin
//   sel        source index (direct mode only)
//   lock       arbitrated mode: hold current owner while its req stays high
//   bus_out    registered bus word
//   bus_valid  bus_out holds a word granted on the previous edge
//   grant      registered one-hot grant (or zero)
//   grant_idx  registered index of the granted source
module rr_bus_mux #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_SRC = 8,
  parameter int unsigned SEL_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SRC*WIDTH-1:0] data_in,
  input  logic [N_SRC-1:0]       req,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   lock,
  output logic [WIDTH-1:0]       bus_out,
  output logic                   bus_valid,
  output logic [N_SRC-1:0]       grant,
  output logic [SEL_W-1:0]       grant_idx
);

  // Word of source idx; zero for an index with no source behind it.
  function automatic logic [WIDTH-1:0] pick_word(input logic [N_SRC*WIDTH-1:0] d,
                                                 input logic [SEL_W-1:0]       idx);
    logic [WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (idx == SEL_W'(i)) w = d[i*WIDTH +: WIDTH];
    end
    return w;
  endfunction

  // One-hot of idx; zero for an index beyond the last source.
  function automatic logic [N_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_SRC-1:0] oh;
    oh = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (idx == SEL_W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  // State
  logic [WIDTH-1:0] bus_out_q, bus_out_d;
  logic             bus_valid_q, bus_valid_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] grant_idx_q, grant_idx_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic             owner_valid_q, owner_valid_d;

  // Arbitration intermediates
  logic             direct_ok;
  logic             owner_req;
  logic             hold;
  logic             rr_found;
  logic [SEL_W-1:0] rr_idx;
  logic             win_found;
  logic [SEL_W-1:0] win_idx;

  // Widened compare so a fully populated select space does not overflow the constant.
  assign direct_ok = ({1'b0, sel} < (SEL_W+1)'(N_SRC));

  // Request bit of the current owner.
  always_comb begin
    owner_req = 1'b0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (grant_idx_q == SEL_W'(i)) owner_req = req[i];
    end
  end

  // Round-robin scan: last+1, last+2, ... wrapping at N_SRC; last itself is visited last.
  always_comb begin
    logic [SEL_W-1:0] cand;
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = 1; k <= int'(N_SRC); k++) begin
      cand = SEL_W'((int'(last_q) + k) % int'(N_SRC));
      if (!rr_found && req[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // Lock keeps the owner only while it still requests; a dropped req falls through to the scan
  // on the same edge.
  assign hold      = lock && owner_valid_q && owner_req;
  assign win_found = hold || rr_found;
  assign win_idx   = hold ? grant_idx_q : rr_idx;

  always_comb begin
    bus_out_d     = bus_out_q;
    bus_valid_d   = 1'b0;
    grant_d       = '0;
    grant_idx_d   = grant_idx_q;
    last_d        = last_q;
    owner_valid_d = 1'b0;
    if (!mode) begin
      if (direct_ok) begin
        bus_out_d   = pick_word(data_in, sel);
        bus_valid_d = 1'b1;
        grant_d     = onehot(sel);
        grant_idx_d = sel;
        last_d      = sel;
      end else begin
        bus_out_d   = '0;
        grant_idx_d = '0;
      end
    end else if (win_found) begin
      bus_out_d     = pick_word(data_in, win_idx);
      bus_valid_d   = 1'b1;
      grant_d       = onehot(win_idx);
      grant_idx_d   = win_idx;
      last_d        = win_idx;
      owner_valid_d = 1'b1;
    end
    // Arbitrated idle: bus_out and grant_idx keep their last values.
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_out_q     <= '0;
      bus_valid_q   <= 1'b0;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      last_q        <= SEL_W'(N_SRC - 1);
      owner_valid_q <= 1'b0;
    end else begin
      bus_out_q     <= bus_out_d;
      bus_valid_q   <= bus_valid_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      last_q        <= last_d;
      owner_valid_q <= owner_valid_d;
    end
  end

  assign bus_out   = bus_out_q;
  assign bus_valid = bus_valid_q;
  assign grant     = grant_q;
  assign grant_idx = grant_idx_q;

endmodule

// File: tb/tb_rr_bus_mux.sv
// Directed bench for rr_bus_mux: an 8-source instance plus a 6-source instance sharing the
// stimulus, the latter exercising out-of-range direct selects.
module tb_rr_bus_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] data_in;
  logic [7:0]  req;
  logic        mode;
  logic [2:0]  sel;
  logic        lock;

  logic [7:0]  bus_out;
  logic        bus_valid;
  logic [7:0]  grant;
  logic [2:0]  grant_idx;

  logic [7:0]  bus_out6;
  logic        bus_valid6;
  logic [5:0]  grant6;
  logic [2:0]  grant_idx6;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_bus_mux #(.WIDTH(8), .N_SRC(8), .SEL_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .req       (req),
    .mode      (mode),
    .sel       (sel),
    .lock      (lock),
    .bus_out   (bus_out),
    .bus_valid (bus_valid),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  rr_bus_mux #(.WIDTH(8), .N_SRC(6), .SEL_W(3)) dut6 (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in[47:0]),
    .req       (req[5:0]),
    .mode      (mode),
    .sel       (sel),
    .lock      (lock),
    .bus_out   (bus_out6),
    .bus_valid (bus_valid6),
    .grant     (grant6),
    .grant_idx (grant_idx6)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_out, input logic e_valid,
                           input logic [7:0] e_grant, input logic [2:0] e_idx);
    check({tag, "_out"},   32'(bus_out),   32'(e_out));
    check({tag, "_valid"}, 32'(bus_valid), 32'(e_valid));
    check({tag, "_grant"}, 32'(grant),     32'(e_grant));
    check({tag, "_idx"},   32'(grant_idx), 32'(e_idx));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) data_in[i*8 +: 8] = 8'h10 + 8'(i);
    rst  = 1'b1;
    mode = 1'b1;
    req  = 8'hFF;
    sel  = 3'd2;
    lock = 1'b1;

    // Reset held two cycles with busy inputs.
    step();
    check_all("rst1", 8'h00, 1'b0, 8'h00, 3'd0);
    step();
    check_all("rst2", 8'h00, 1'b0, 8'h00, 3'd0);
    check("rst6_valid", 32'(bus_valid6), 32'd0);

    // First arbitrated request from 0 and 5 starts the scan at 0.
    rst  = 1'b0;
    lock = 1'b0;
    req  = 8'b0010_0001;
    step();
    check_all("first_arb", 8'h10, 1'b1, 8'h01, 3'd0);

    // Direct sweep; the 6-source instance idles for sel 6 and 7.
    mode = 1'b0;
    req  = 8'h00;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      step();
      check_all($sformatf("sweep%0d", s), 8'h10 + 8'(s), 1'b1, 8'(1 << s), 3'(s));
      if (s >= 6) begin
        check($sformatf("oor%0d_valid", s), 32'(bus_valid6), 32'd0);
        check($sformatf("oor%0d_grant", s), 32'(grant6), 32'd0);
        check($sformatf("oor%0d_out", s), 32'(bus_out6), 32'd0);
        check($sformatf("oor%0d_idx", s), 32'(grant_idx6), 32'd0);
      end else if (s == 5) begin
        check("d6_sel5_out", 32'(bus_out6), 32'h15);
        check("d6_sel5_grant", 32'(grant6), 32'h20);
      end
    end

    // Round-robin fairness over sources 0, 3, 7 (last=7 after the sweep).
    mode = 1'b1;
    req  = 8'b1000_1001;
    for (int r = 0; r < 6; r++) begin
      logic [2:0] e;
      e = (r % 3 == 0) ? 3'd0 : (r % 3 == 1) ? 3'd3 : 3'd7;
      step();
      check_all($sformatf("rr%0d", r), 8'h10 + 8'(e), 1'b1, 8'(1 << e), e);
    end

    // Lock: first edge arbitrates to 1, then 1 is held despite 2 requesting.
    req  = 8'b0000_0110;
    lock = 1'b1;
    for (int r = 0; r < 4; r++) begin
      step();
      check_all($sformatf("lock%0d", r), 8'h11, 1'b1, 8'h02, 3'd1);
    end
    // Owner drops req: released and re-arbitrated on the same edge.
    req = 8'b0000_0100;
    step();
    check_all("lock_rel", 8'h12, 1'b1, 8'h04, 3'd2);

    // Grant 3, then go idle: bus_out and grant_idx hold.
    lock = 1'b0;
    req  = 8'b0000_1000;
    step();
    check_all("grant3", 8'h13, 1'b1, 8'h08, 3'd3);
    req = 8'h00;
    step();
    check_all("idle", 8'h13, 1'b0, 8'h00, 3'd3);

    // Direct pick of 4 biases the next scan to start at 5; word 5 changes on the grant edge.
    mode = 1'b0;
    sel  = 3'd4;
    step();
    check_all("sw_direct", 8'h14, 1'b1, 8'h10, 3'd4);
    mode = 1'b1;
    req  = 8'hFF;
    data_in[47:40] = 8'hA5;
    step();
    check_all("sw_arb", 8'hA5, 1'b1, 8'h20, 3'd5);

    // Lock on source 2, then reset mid-transfer.
    data_in[47:40] = 8'h15;
    req  = 8'h04;
    lock = 1'b1;
    step();
    check_all("pre_rst", 8'h12, 1'b1, 8'h04, 3'd2);
    rst = 1'b1;
    step();
    check_all("mid_rst", 8'h00, 1'b0, 8'h00, 3'd0);
    rst = 1'b0;
    step();
    check_all("post_rst", 8'h12, 1'b1, 8'h04, 3'd2);

    // Reset restarts the scan at 0: with 0 and 7 requesting, 0 wins.
    rst = 1'b1;
    step();
    rst  = 1'b0;
    lock = 1'b0;
    req  = 8'h81;
    step();
    check_all("rst_ptr", 8'h10, 1'b1, 8'h01, 3'd0);
    step();
    check_all("rst_ptr_next", 8'h17, 1'b1, 8'h80, 3'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_bus_mux.md
Name: rr_bus_mux

Overview:
- Parametrised, registered successor to the CPU's 8-way combinational data bus.
- Selects one of N_SRC source words onto a shared WIDTH-bit bus and registers the result.
- Two modes:
  - Direct: the control unit drives the select index, as before.
  - Arbitrated: round-robin between requesting sources, with optional grant lock for multi-cycle transfers.
- Sits between register file, ALU, memory data port and the bus consumers.

Parameters:
- WIDTH, 8, bit width of each source word and of the bus.
- N_SRC, 8, number of sources (2..16).
- SEL_W, 3, width of the select and index fields; must satisfy 2**SEL_W >= N_SRC.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- data_in  input  N_SRC*WIDTH  flattened source words; source i occupies bits [i*WIDTH +: WIDTH].
- req  input  N_SRC  per-source bus request (arbitrated mode only).
- mode  input  1  0 = direct select, 1 = round-robin arbitration.
- sel  input  SEL_W  source index (direct mode only).
- lock  input  1  arbitrated mode: keep the current owner while its req stays high.
- bus_out  output  WIDTH  registered bus value.
- bus_valid  output  1  bus_out holds a word granted in the previous cycle.
- grant  output  N_SRC  registered one-hot grant.
- grant_idx  output  SEL_W  registered index of the granted source.

Behaviour:
- Reset and clocking:
  - One clock domain; reset is synchronous and active-high, and has priority over everything.
  - Reset values: bus_out=0, bus_valid=0, grant=0, grant_idx=0, internal pointer last=N_SRC-1 (first scan starts at source 0), internal owner_valid=0.
  - Reset asserted mid-transfer drops the grant and lock ownership on that edge.
- Latency:
  - All outputs are registered; inputs sampled at edge k appear on outputs after edge k.
  - data_in is sampled on the same edge as the grant decision: bus_out = data_in word of the winner at that edge.
- Direct mode (mode=0), each edge:
  - If sel < N_SRC: bus_out<=word[sel], bus_valid<=1, grant<=onehot(sel), grant_idx<=sel, last<=sel.
  - If sel >= N_SRC: bus_out<=0, bus_valid<=0, grant<=0, grant_idx<=0, last unchanged.
  - req and lock are ignored.
  - owner_valid<=0.
- Arbitrated mode (mode=1), each edge:
  - Lock hold: if lock=1, owner_valid=1 and req[grant_idx]=1, the winner is grant_idx and last is unchanged.
  - Otherwise the winner is the first i with req[i]=1, scanning last+1, last+2, ... modulo N_SRC; last itself is checked last.
  - Winner found: bus_out<=word[winner], bus_valid<=1, grant<=onehot(winner), grant_idx<=winner, last<=winner, owner_valid<=1.
  - No request: bus_valid<=0, grant<=0, owner_valid<=0; bus_out and grant_idx hold their previous values; last unchanged.
  - The owner dropping req while lock=1 releases the lock immediately; arbitration runs on that same edge, scanning from last+1.
  - Request bits at index >= N_SRC do not exist; no wrap beyond N_SRC-1.
- Mode switching:
  - A mode change takes effect on the edge where the new value is sampled.
  - The last pointer carries across the switch, so a direct selection biases the next round-robin scan.
- Invariants:
  - grant is zero or one-hot.
  - bus_valid == |grant.
  - When bus_valid=1, grant_idx matches the grant bit.
- Implementation notes:
  - Combinational next-state logic plus one always block on posedge clk.
  - No latches; the default case assigns all next-state values.

Test Plan:
- Reset: hold rst for 2 cycles with arbitrary inputs -> bus_out=0, bus_valid=0, grant=0, grant_idx=0; first arbitrated request from sources 0 and 5 grants source 0.
- Direct sweep: WIDTH=8, N_SRC=8, data_in word i = 8'h10+i, mode=0, sel=0..7 on consecutive cycles -> each cycle after the edge, bus_out=8'h10+sel, grant=1<<sel, bus_valid=1.
- Direct out-of-range: N_SRC=6, sel=7 -> bus_valid=0, grant=0, bus_out=0.
- Round-robin fairness: mode=1, req=8'b1000_1001 held for 6 cycles -> grant_idx sequence 0,3,7,0,3,7.
- Lock: mode=1, req=8'b0000_0110, lock=1 for 4 cycles -> grant_idx=1 for all 4 cycles. Then drop req[1] -> next grant_idx=2 on that edge.
- Idle and switch:
  - mode=1, req=0 after granting 3 -> bus_valid=0, bus_out holds word 3, grant_idx=3.
  - Then mode=0, sel=4, then mode=1, req=8'hFF -> grant_idx 4 then 5.
- Mid-transfer reset: lock held on source 2, assert rst for 1 cycle -> outputs cleared. Then req=8'h04 with lock=1 -> grant_idx=2 (last=N_SRC-1 restart), bus_valid=1.
